// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the two-requester APB command arbiter:
// FSM state encodings, default bus widths and read/write direction constants.
package apb_req_arbiter_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Two-input round-robin grant with a last-grant pointer that moves only
// when a grant is actually taken.
module rr_arb2 (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted most recently, so requester 0 wins a tie
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      last_q <= 1'b1;
    end else if (accept && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between two requesters: round-robin accept, one
// command in flight, single-cycle response routed back to the owner.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              m_transfer,
  output logic              m_read_write,
  output logic [ADDR_W-1:0] m_write_paddr,
  output logic [ADDR_W-1:0] m_read_paddr,
  output logic [DATA_W-1:0] m_write_data,
  input  logic              m_penable,
  input  logic              m_pready,
  input  logic [DATA_W-1:0] m_read_data
);

  arb_state_e        state_q, state_d;
  logic              idle_ok;
  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  logic              accept;

  logic              owner_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Ready is combinational from valid, so it is also held low during reset.
  assign idle_ok = (state_q == IDLE) && !PRESET;
  assign req_vld = {req1_valid, req0_valid} & {2{idle_ok}};

  rr_arb2 u_rr (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .req    (req_vld),
    .accept (accept),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = gnt[0] | gnt[1];

  assign sel_write = gnt[1] ? req1_write : req0_write;
  assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
  assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (m_penable && m_pready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch: the master sees only these registers from ISSUE to RESP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner_q <= gnt[1];
      rd_q    <= sel_write ? RW_WRITE : RW_READ;
      addr_q  <= sel_addr;
      wdata_q <= sel_write ? sel_wdata : '0;
    end
  end

  assign m_transfer    = (state_q == ISSUE);
  assign m_read_write  = rd_q;
  assign m_write_paddr = addr_q;
  assign m_read_paddr  = addr_q;
  assign m_write_data  = wdata_q;

  assign busy       = (state_q != IDLE) || accept;
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp_rdata  = ((state_q == RESP) && (rd_q == RW_READ)) ? m_read_data : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a behavioural APB master/slave
// whose wait-state count is set per transaction.
module tb_apb_req_arbiter;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req0_valid, req0_ready, req0_write;
  logic [8:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_write;
  logic [8:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_rdata;
  logic       busy, m_transfer, m_read_write;
  logic [8:0] m_write_paddr, m_read_paddr;
  logic [7:0] m_write_data;
  logic       m_penable, m_pready;
  logic [7:0] m_read_data;

  int errors = 0;
  int checks = 0;
  int ws = 0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_write    (req0_write),
    .req0_addr     (req0_addr),
    .req0_wdata    (req0_wdata),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_write    (req1_write),
    .req1_addr     (req1_addr),
    .req1_wdata    (req1_wdata),
    .rsp0_valid    (rsp0_valid),
    .rsp1_valid    (rsp1_valid),
    .rsp_rdata     (rsp_rdata),
    .busy          (busy),
    .m_transfer    (m_transfer),
    .m_read_write  (m_read_write),
    .m_write_paddr (m_write_paddr),
    .m_read_paddr  (m_read_paddr),
    .m_write_data  (m_write_data),
    .m_penable     (m_penable),
    .m_pready      (m_pready),
    .m_read_data   (m_read_data)
  );

  // Behavioural APB master + slave memory; the master uses active-low reset.
  logic       presetn;
  logic [1:0] mst;
  int         wcnt;
  logic [8:0] maddr;
  logic       mrd;
  logic [7:0] mdat;
  logic [7:0] mem [0:511];
  logic       mem_init = 1'b0;
  logic [8:0] last_waddr;
  logic [7:0] last_wdata;

  assign presetn   = ~PRESET;
  assign m_penable = (mst == 2'd2);
  assign m_pready  = (mst == 2'd2) && (wcnt == ws);

  always @(posedge PCLK or negedge presetn) begin
    if (!presetn) begin
      mst         <= 2'd0;
      wcnt        <= 0;
      m_read_data <= 8'h00;
      if (!mem_init) begin
        for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        mem[9'h105] <= 8'h3C;
        mem_init    <= 1'b1;
        last_waddr  <= 9'h000;
        last_wdata  <= 8'h00;
      end
    end else begin
      case (mst)
        2'd0: if (m_transfer) begin
          mst   <= 2'd1;
          maddr <= m_write_paddr;
          mrd   <= m_read_write;
          mdat  <= m_write_data;
        end
        2'd1: mst <= 2'd2;
        default: begin
          if (wcnt == ws) begin
            mst  <= 2'd0;
            wcnt <= 0;
            if (mrd) m_read_data <= mem[maddr];
            else begin
              mem[maddr] <= mdat;
              last_waddr <= maddr;
              last_wdata <= mdat;
            end
          end else begin
            wcnt <= wcnt + 1;
          end
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v0, v1, wr;
    logic [8:0] a;
    logic [7:0] d;
    int         ws;
    logic       r0, r1;
    int         lat;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(logic v0, logic v1, logic wr, logic [8:0] a, logic [7:0] d,
                              int w, logic r0, logic r1, int lat, logic [7:0] rd);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.wr = wr; v.a = a; v.d = d; v.ws = w;
    v.r0 = r0; v.r1 = r1; v.lat = lat; v.rd = rd;
    return v;
  endfunction

  // Drive one command (valids held for the whole transaction) and follow it to RESP.
  task automatic do_txn(input vec_t v);
    bit seen = 0;
    @(negedge PCLK);
    ws = v.ws;
    req0_valid = v.v0; req0_write = v.wr; req0_addr = v.a; req0_wdata = v.d;
    req1_valid = v.v1; req1_write = v.wr; req1_addr = v.a; req1_wdata = v.d;
    #1;
    chk("ready0", req0_ready, v.r0);
    chk("ready1", req1_ready, v.r1);
    chk("busy_accept", busy, 1);
    for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
      @(negedge PCLK); #1;
      chk("ready_while_busy", {req1_ready, req0_ready}, 0);
      chk("busy", busy, 1);
      chk("transfer", m_transfer, (cyc == 1));
      if (m_transfer) chk("xfer_master_idle", mst, 0);
      if (cyc == 1) begin
        chk("m_read_write", m_read_write, !v.wr);
        chk("m_write_paddr", m_write_paddr, v.a);
        chk("m_read_paddr", m_read_paddr, v.a);
        chk("m_write_data", m_write_data, v.wr ? v.d : 8'h00);
      end
      if (rsp0_valid || rsp1_valid) begin
        seen = 1;
        chk("rsp_latency", cyc, v.lat);
        chk("rsp0_valid", rsp0_valid, v.r0);
        chk("rsp1_valid", rsp1_valid, v.r1);
        chk("rsp_rdata", rsp_rdata, v.rd);
        if (v.wr) begin
          chk("slave_waddr", last_waddr, v.a);
          chk("slave_wdata", last_wdata, v.d);
        end
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  vec_t vecs [9];
  bit   seen_b;

  initial begin
    PRESET = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h1FF; req0_wdata = 8'hFF;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h1FF; req1_wdata = 8'hFF;

    // Reset state with both valids asserted
    repeat (2) @(negedge PCLK);
    #1;
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_m_cmd", {m_transfer, m_read_write, m_write_paddr, m_read_paddr, m_write_data}, 0);
    @(negedge PCLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    PRESET = 1'b0;

    vecs[0] = mk(1, 0, 1, 9'h012, 8'hA5, 0, 1, 0, 4, 8'h00);
    vecs[1] = mk(0, 1, 0, 9'h105, 8'h00, 2, 0, 1, 6, 8'h3C);
    vecs[2] = mk(1, 1, 0, 9'h012, 8'h00, 0, 1, 0, 4, 8'hA5);
    vecs[3] = mk(1, 1, 1, 9'h0FF, 8'h5A, 1, 0, 1, 5, 8'h00);
    vecs[4] = mk(1, 1, 0, 9'h0FF, 8'h00, 0, 1, 0, 4, 8'h5A);
    vecs[5] = mk(1, 1, 1, 9'h1AB, 8'hC3, 0, 0, 1, 4, 8'h00);
    vecs[6] = mk(0, 1, 0, 9'h1AB, 8'h00, 3, 0, 1, 7, 8'hC3);
    vecs[7] = mk(1, 0, 0, 9'h105, 8'h00, 0, 1, 0, 4, 8'h3C);
    vecs[8] = mk(1, 1, 0, 9'h1AB, 8'h00, 0, 0, 1, 4, 8'hC3);
    for (int i = 0; i < 9; i++) do_txn(vecs[i]);
    @(negedge PCLK);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Requester inputs change mid-transaction; latched command must hold
    @(negedge PCLK);
    ws = 3;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h0AA; req1_wdata = 8'h11;
    seen_b = 0;
    for (int cyc = 1; cyc <= 30 && !seen_b; cyc++) begin
      @(negedge PCLK);
      if (cyc == 2) begin
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 9'h155; req1_wdata = 8'hEE;
        req0_valid = 1'b1;
      end
      if (cyc == 3) req0_valid = 1'b0;
      #1;
      chk("hold_cmd", {m_read_write, m_write_paddr, m_read_paddr, m_write_data},
          {1'b0, 9'h0AA, 9'h0AA, 8'h11});
      if (rsp0_valid || rsp1_valid) begin
        seen_b = 1;
        chk("hold_latency", cyc, 7);
        chk("hold_rsp", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("hold_slave", {last_waddr, last_wdata}, {9'h0AA, 8'h11});
      end
    end
    if (!seen_b) chk("hold_timeout", 0, 1);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge PCLK); #1;
      chk("dropped_valid_idle", {busy, m_transfer}, 0);
    end

    // Reset while the slave stalls in WAIT
    @(negedge PCLK);
    ws = 200;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h012;
    repeat (3) @(negedge PCLK);
    #1;
    chk("stall_in_wait", {busy, m_penable, m_pready}, 3'b110);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", {rsp1_valid, rsp0_valid, rsp_rdata}, 0);
    chk("mid_rst_m_cmd", {m_transfer, m_read_write, m_write_paddr, m_read_paddr, m_write_data}, 0);
    repeat (2) @(negedge PCLK);
    req0_valid = 1'b0;
    PRESET = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge PCLK); #1;
      chk("post_rst_quiet", {rsp1_valid, rsp0_valid, busy}, 0);
    end
    do_txn(mk(1, 1, 0, 9'h012, 8'h00, 0, 1, 0, 4, 8'hA5));
    @(negedge PCLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge PCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
